// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction width, NOP encoding
// and the big-endian instruction word type used by the pipeline stages.
package proc_pkg;

   localparam int INSTR_W = 32;

   typedef logic [0:INSTR_W-1] instr_t;

   localparam instr_t NOP_INSTR = 32'h0000_0000;

endpackage : proc_pkg

// File: rtl/pipe_reg.sv
// Generic WIDTH-bit pipeline register with asynchronous active-low
// reset to a parameterised value; shared by every pipeline stage.
module pipe_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [0:WIDTH-1] RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [0:WIDTH-1]   d,
   output logic [0:WIDTH-1]   q
);

   logic [0:WIDTH-1] data_d;
   logic [0:WIDTH-1] data_q;

   // Next value: the stage always advances, no enable or stall.
   always_comb begin
      data_d = d;
   end

   // Storage: reset wins over a coincident clock edge and clears X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= RST_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : pipe_reg

// File: rtl/pipe1.sv
// Stage-1 instruction pipeline register: delays the fetched word by
// one cycle and holds a NOP while reset is low.
module pipe1
   import proc_pkg::*;
#(
   parameter int               WIDTH    = INSTR_W,
   parameter logic [0:WIDTH-1] NOP_WORD = WIDTH'(NOP_INSTR)
) (
   input  logic [0:WIDTH-1] instruction_in,
   output logic [0:WIDTH-1] instruction_out,
   input  logic             clk,
   input  logic             reset
);

   pipe_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (NOP_WORD)
   ) u_instr_reg (
      .clk   (clk),
      .rst_n (reset),
      .d     (instruction_in),
      .q     (instruction_out)
   );

endmodule : pipe1

// File: tb/tb_pipe1.sv
// Directed self-checking bench for pipe1: reset, latency, async
// reset, bit order and a back-to-back stream with mid-stream reset.
module tb_pipe1;

   logic [0:31] instruction_in;
   logic [0:31] instruction_out;
   logic        clk;
   logic        reset;

   int checks;
   int errors;

   pipe1 dut (
      .instruction_in  (instruction_in),
      .instruction_out (instruction_out),
      .clk             (clk),
      .reset           (reset)
   );

   initial begin
      clk = 1'b0;
      #10;
      forever begin
         clk = 1'b1;
         #5;
         clk = 1'b0;
         #5;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      instruction_in = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (instruction_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_init got %h want %h",
                  instruction_out, 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (instruction_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold%0d got %h want %h",
                     i, instruction_out, 32'h0);
         end
      end
   endtask

   task automatic test_latency();
      logic [0:31] vec [3];
      logic [0:31] prev;
      vec[0] = 32'h0000_0000;
      vec[1] = 32'h0000_0001;
      vec[2] = 32'h0000_0002;
      prev = 32'h0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instruction_in = vec[i];
         #1;
         checks++;
         if (instruction_out !== prev) begin
            errors++;
            $display("FAIL latency_pre%0d got %h want %h",
                     i, instruction_out, prev);
         end
         step();
         checks++;
         if (instruction_out !== vec[i]) begin
            errors++;
            $display("FAIL latency%0d got %h want %h",
                     i, instruction_out, vec[i]);
         end
         prev = vec[i];
      end
   endtask

   task automatic test_async_reset();
      instruction_in = 32'hDEAD_BEEF;
      step();
      checks++;
      if (instruction_out !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL async_load got %h want %h",
                  instruction_out, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (instruction_out !== 32'h0) begin
         errors++;
         $display("FAIL async_clear got %h want %h",
                  instruction_out, 32'h0);
      end
      step();
      checks++;
      if (instruction_out !== 32'h0) begin
         errors++;
         $display("FAIL async_edge got %h want %h",
                  instruction_out, 32'h0);
      end
      reset = 1'b1;
      instruction_in = 32'h1234_5678;
      step();
      checks++;
      if (instruction_out !== 32'h1234_5678) begin
         errors++;
         $display("FAIL async_release got %h want %h",
                  instruction_out, 32'h1234_5678);
      end
   endtask

   task automatic test_bit_order();
      logic [0:31] mid;
      instruction_in = 32'h8000_0001;
      step();
      mid = instruction_out;
      mid[0] = 1'b0;
      mid[31] = 1'b0;
      checks++;
      if (instruction_out[0] !== 1'b1) begin
         errors++;
         $display("FAIL bit0 got %b want %b",
                  instruction_out[0], 1'b1);
      end
      checks++;
      if (instruction_out[31] !== 1'b1) begin
         errors++;
         $display("FAIL bit31 got %b want %b",
                  instruction_out[31], 1'b1);
      end
      checks++;
      if (mid !== 32'h0) begin
         errors++;
         $display("FAIL bit_others got %h want %h", mid, 32'h0);
      end
      checks++;
      if (instruction_out !== 32'h8000_0001) begin
         errors++;
         $display("FAIL bit_word got %h want %h",
                  instruction_out, 32'h8000_0001);
      end
   endtask

   task automatic test_back_to_back();
      logic [0:31] w;
      logic [0:31] prev;
      prev = instruction_out;
      reset = 1'b1;
      for (int n = 0; n < 16; n++) begin
         if (n == 8) begin
            reset = 1'b0;
            #1;
            checks++;
            if (instruction_out !== 32'h0) begin
               errors++;
               $display("FAIL b2b_reset got %h want %h",
                        instruction_out, 32'h0);
            end
            prev = 32'h0;
            reset = 1'b1;
         end
         w = $urandom;
         instruction_in = w;
         #1;
         checks++;
         if (instruction_out !== prev) begin
            errors++;
            $display("FAIL b2b_hold%0d got %h want %h",
                     n, instruction_out, prev);
         end
         step();
         checks++;
         if (instruction_out !== w) begin
            errors++;
            $display("FAIL b2b%0d got %h want %h",
                     n, instruction_out, w);
         end
         prev = w;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_latency();
      test_async_reset();
      test_bit_order();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe1
